// File: rtl/pdp8_stim_seq_if.sv
// pdp8_stim_seq_if: directed-vector handshake into the PDP8 stimulus sequencer.
// master = vector source (valid/payload out, ready in); slave = sequencer.
interface pdp8_stim_seq_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  dir_valid;
    logic                  dir_ready;
    logic                  dir_is_mem;
    logic [21:0]           dir_code;
    logic [ADDR_WIDTH-1:0] dir_addr;
    logic                  dir_last;

    modport master (
        output dir_valid,
        output dir_is_mem,
        output dir_code,
        output dir_addr,
        output dir_last,
        input  dir_ready
    );

    modport slave (
        input  dir_valid,
        input  dir_is_mem,
        input  dir_code,
        input  dir_addr,
        input  dir_last,
        output dir_ready
    );
endinterface

// File: rtl/pdp8_stim_seq.sv
// pdp8_stim_seq: issues directed or LFSR-random PDP8 decode structs under stall.
// Ports: clk, reset_n, stall, PC_value, start/stop/mode/num_instr, dir (vectors),
//        base_addr, pdp_mem_opcode, pdp_op7_opcode, busy, done, issued_count.
package pdp8_stim_pkg;
    localparam int PDP_ADDR_W = 12;

    typedef struct packed {
        logic [5:0]            code;
        logic [PDP_ADDR_W-1:0] addr;
    } pdp_mem_opcode_s;

    typedef struct packed {
        logic [21:0] code;
    } pdp_op7_opcode_s;
endpackage

module pdp8_stim_seq
    import pdp8_stim_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 12,
    parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 12'o0200,
    parameter int                    MAX_DELAY     = 20,
    parameter logic [31:0]           SEED          = 32'h1,
    parameter int                    CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [CNT_WIDTH-1:0]  num_instr,
    pdp8_stim_seq_if.slave        dir,
    output logic [ADDR_WIDTH-1:0] base_addr,
    output pdp_mem_opcode_s       pdp_mem_opcode,
    output pdp_op7_opcode_s       pdp_op7_opcode,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  issued_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_HOLD1,
        S_HOLD,
        S_GAP,
        S_DONE
    } state_e;

    localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] DLY_MOD   = 32'(MAX_DELAY + 1);

    state_e                 state, state_nx;
    logic [31:0]            lfsr;
    logic [31:0]            lfsr_nx;
    logic                   src_rand;
    logic                   mode2_q;
    logic [CNT_WIDTH-1:0]   num_q;
    logic                   stop_pend;
    logic [7:0]             gap_cnt;
    logic [7:0]             gap_ld;

    logic                   stop_now;
    logic                   busy_state;
    logic                   start_acc;
    logic                   issue;
    logic                   issue_rand;
    logic                   retire;
    logic                   dir_ready_c;
    logic                   hit;
    logic [CNT_WIDTH-1:0]   cnt_inc;

    logic [4:0]             sel;
    logic [5:0]             rmem_code;
    logic [21:0]            rop7_code;
    logic [7:0]             rdelay;

    logic                   unused_pc;

    assign unused_pc  = ^PC_value;
    assign base_addr  = START_ADDRESS;

    assign stop_now   = stop | stop_pend;
    assign busy_state = (state != S_IDLE) && (state != S_DONE);
    assign start_acc  = start && !busy_state;

    // Saturating increment; a run of exactly num_instr ends on the
    // post-increment value so the final instruction is counted once.
    assign cnt_inc = (issued_count == '1) ? issued_count
                                          : issued_count + CNT_WIDTH'(1);
    assign hit     = (num_q != '0) && (cnt_inc == num_q);

    // Galois step, right shift.
    assign lfsr_nx = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);

    // Random decode, always from the pre-advance LFSR state.
    assign sel       = lfsr[5:1];
    assign rmem_code = 6'd1 << (sel % 5'd6);
    assign rop7_code = 22'd1 << (sel % 5'd22);
    assign rdelay    = 8'({24'd0, lfsr[31:24]} % DLY_MOD);

    assign dir.dir_ready = dir_ready_c;

    always_comb begin
        state_nx    = state;
        issue       = 1'b0;
        issue_rand  = 1'b0;
        retire      = 1'b0;
        dir_ready_c = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nx = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                // Nothing is driven here, so a stop ends the run at once;
                // ready is withheld so no vector is swallowed by it.
                if (stop_now) begin
                    state_nx = S_DONE;
                end else if (!stall) begin
                    if (src_rand) begin
                        issue      = 1'b1;
                        issue_rand = 1'b1;
                        state_nx   = S_HOLD1;
                    end else begin
                        dir_ready_c = 1'b1;
                        if (dir.dir_valid) begin
                            issue    = 1'b1;
                            state_nx = S_HOLD1;
                        end
                    end
                end
            end
            S_HOLD1: begin
                state_nx = S_HOLD;
            end
            S_HOLD: begin
                if (!stall) begin
                    retire   = 1'b1;
                    state_nx = (hit || stop_now) ? S_DONE : S_GAP;
                end
            end
            S_GAP: begin
                if (stop_now)
                    state_nx = S_DONE;
                else if (gap_cnt == 8'd0)
                    state_nx = S_WAIT_RDY;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            lfsr           <= LFSR_INIT;
            src_rand       <= 1'b0;
            mode2_q        <= 1'b0;
            num_q          <= '0;
            stop_pend      <= 1'b0;
            gap_cnt        <= '0;
            gap_ld         <= '0;
            pdp_mem_opcode <= '0;
            pdp_op7_opcode <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            issued_count   <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != S_IDLE) && (state_nx != S_DONE);
            done  <= (state_nx == S_DONE);

            if (start_acc) begin
                // Mode 3 is reserved and behaves as random (bit 0 set).
                src_rand     <= mode[0];
                mode2_q      <= (mode == 2'd2);
                num_q        <= num_instr;
                issued_count <= '0;
                stop_pend    <= 1'b0;
            end else if (busy_state && stop) begin
                stop_pend <= 1'b1;
            end

            if (issue) begin
                if (issue_rand) begin
                    if (lfsr[0]) begin
                        pdp_mem_opcode.code <= rmem_code;
                        pdp_mem_opcode.addr <= PDP_ADDR_W'(lfsr[ADDR_WIDTH+5:6]);
                        pdp_op7_opcode      <= '0;
                    end else begin
                        pdp_mem_opcode      <= '0;
                        pdp_op7_opcode.code <= rop7_code;
                    end
                    gap_ld <= rdelay;
                    lfsr   <= lfsr_nx;
                end else begin
                    if (dir.dir_is_mem) begin
                        pdp_mem_opcode.code <= dir.dir_code[5:0];
                        pdp_mem_opcode.addr <= PDP_ADDR_W'(dir.dir_addr);
                        pdp_op7_opcode      <= '0;
                    end else begin
                        pdp_mem_opcode      <= '0;
                        pdp_op7_opcode.code <= dir.dir_code;
                    end
                    gap_ld <= 8'd0;
                    // Switch takes effect from the next instruction; this
                    // one still gets the directed (zero) gap.
                    if (mode2_q && dir.dir_last) src_rand <= 1'b1;
                end
            end

            if (retire) begin
                pdp_mem_opcode <= '0;
                pdp_op7_opcode <= '0;
                issued_count   <= cnt_inc;
                gap_cnt        <= gap_ld;
            end else if (state == S_GAP && gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pdp8_stim_seq.sv
// tb_pdp8_stim_seq: scoreboard bench for the PDP8 stimulus sequencer.
// Expected instructions are queued at stimulus time and checked by a monitor.
module tb_pdp8_stim_seq;
    import pdp8_stim_pkg::*;

    localparam int MAXD = 20;

    typedef struct {
        bit          is_mem;
        logic [21:0] code;
        logic [11:0] addr;
        int          len;
        int          idle;
    } ins_t;

    typedef struct {
        bit          is_mem;
        logic [21:0] code;
        logic [11:0] addr;
        bit          last;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            stall;
    logic            start;
    logic            stop;
    logic [1:0]      mode;
    logic [15:0]     num_instr;
    logic [11:0]     pc_value;
    logic [11:0]     base_addr;
    pdp_mem_opcode_s mem_op;
    pdp_op7_opcode_s op7_op;
    logic            busy;
    logic            done;
    logic [15:0]     issued_count;

    pdp8_stim_seq_if #(.ADDR_WIDTH(12)) dif ();

    pdp8_stim_seq dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .PC_value       (pc_value),
        .start          (start),
        .stop           (stop),
        .mode           (mode),
        .num_instr      (num_instr),
        .dir            (dif),
        .base_addr      (base_addr),
        .pdp_mem_opcode (mem_op),
        .pdp_op7_opcode (op7_op),
        .busy           (busy),
        .done           (done),
        .issued_count   (issued_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    ins_t        exp_q[$];
    ins_t        rec_q[$];
    vec_t        dv_q[$];
    bit          rec_en = 0;
    bit          mon_en = 0;
    logic [31:0] m_lfsr;
    int          first_nz;
    int          ready_late;
    int          n_acc;

    // Monitor state
    bit          m_act = 0;
    int          m_zero = 0;
    bit          m_bad;
    logic [39:0] m_snap;
    ins_t        m_cur;
    ins_t        m_exp;

    function automatic logic [31:0] lfsr_step(logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    endfunction

    always @(negedge clk) begin
        if (!mon_en) begin
            m_act  = 0;
            m_zero = 0;
        end else if (mem_op != '0 || op7_op != '0) begin
            if (!m_act) begin
                m_act        = 1;
                m_snap       = {mem_op, op7_op};
                m_cur.is_mem = (mem_op != '0);
                m_cur.code   = m_cur.is_mem ? {16'd0, mem_op.code} : op7_op.code;
                m_cur.addr   = mem_op.addr;
                m_cur.len    = 1;
                m_cur.idle   = m_zero;
                m_bad        = (mem_op != '0 && op7_op != '0) || !$onehot(m_cur.code);
            end else begin
                m_cur.len++;
                if ({mem_op, op7_op} !== m_snap) m_bad = 1;
            end
        end else begin
            if (m_act) begin
                m_act  = 0;
                m_zero = 0;
                if (rec_en) rec_q.push_back(m_cur);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got mem=%0b code=%h addr=%o, required no instruction",
                             m_cur.is_mem, m_cur.code, m_cur.addr);
                end else begin
                    m_exp = exp_q.pop_front();
                    if ({m_cur.is_mem, m_cur.code, m_cur.addr} !==
                        {m_exp.is_mem, m_exp.code, m_exp.addr}) begin
                        n_fail++;
                        $display("FAIL sb_instr: got mem=%0b code=%h addr=%o, required mem=%0b code=%h addr=%o",
                                 m_cur.is_mem, m_cur.code, m_cur.addr,
                                 m_exp.is_mem, m_exp.code, m_exp.addr);
                    end
                    n_checks++;
                    if (m_cur.len !== m_exp.len) begin
                        n_fail++;
                        $display("FAIL sb_len: got %0d cycles, required %0d", m_cur.len, m_exp.len);
                    end
                    if (m_exp.idle >= 0) begin
                        n_checks++;
                        if (m_cur.idle !== m_exp.idle) begin
                            n_fail++;
                            $display("FAIL sb_idle: got %0d idle cycles, required %0d",
                                     m_cur.idle, m_exp.idle);
                        end
                    end
                    n_checks++;
                    if (m_bad !== 1'b0) begin
                        n_fail++;
                        $display("FAIL sb_onehot: got bad=%0b (not one-hot/exclusive/stable), required 0", m_bad);
                    end
                end
            end
            m_zero++;
        end
    end

    task automatic do_reset();
        mon_en         = 0;
        reset_n        = 0;
        stall          = 0;
        start          = 0;
        stop           = 0;
        mode           = 2'd0;
        num_instr      = 16'd0;
        dif.dir_valid  = 0;
        dif.dir_is_mem = 0;
        dif.dir_code   = '0;
        dif.dir_addr   = '0;
        dif.dir_last   = 0;
        repeat (3) @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        exp_q.delete();
        m_lfsr = 32'h1;
        mon_en = 1;
    endtask

    task automatic push_exp(bit is_mem, logic [21:0] code, logic [11:0] addr, int len, int idle);
        ins_t e;
        e.is_mem = is_mem;
        e.code   = code;
        e.addr   = addr;
        e.len    = len;
        e.idle   = idle;
        exp_q.push_back(e);
    endtask

    task automatic push_vec(bit is_mem, logic [21:0] code, logic [11:0] addr, bit last);
        vec_t v;
        v.is_mem = is_mem;
        v.code   = code;
        v.addr   = addr;
        v.last   = last;
        dv_q.push_back(v);
    endtask

    task automatic push_random(int n, int first_idle);
        logic [31:0] l;
        int idle = first_idle;
        for (int i = 0; i < n; i++) begin
            l = m_lfsr;
            if (l[0])
                push_exp(1, 22'd1 << (int'(l[5:1]) % 6), l[17:6], 2, idle);
            else
                push_exp(0, 22'd1 << (int'(l[5:1]) % 22), 12'd0, 2, idle);
            idle   = (int'(l[31:24]) % (MAXD + 1)) + 2;
            m_lfsr = lfsr_step(l);
        end
    endtask

    task automatic start_run(logic [1:0] m, logic [15:0] n);
        @(negedge clk);
        mode      = m;
        num_instr = n;
        start     = 1;
        n_acc     = 0;
    endtask

    task automatic run(int budget, int stall_inst, int stall_n, int stop_inst,
                       int restart_inst, int sw_after);
        int cyc = 0;
        int inst = 0;
        int vcyc = 0;
        int stall_left = 0;
        bit nz;
        first_nz   = -1;
        ready_late = 0;
        while (1) begin
            @(negedge clk);
            start = 0;
            stop  = 0;
            nz = (mem_op != '0) || (op7_op != '0);
            if (nz) begin
                if (vcyc == 0) inst++;
                vcyc++;
                if (first_nz < 0) first_nz = cyc;
            end else begin
                vcyc = 0;
            end
            if (done) break;
            if (cyc >= budget) begin
                n_checks++;
                n_fail++;
                $display("FAIL run_timeout: got no done after %0d cycles, required done", cyc);
                break;
            end
            if (nz && vcyc == 2 && inst == stall_inst) stall_left = stall_n;
            stall = (stall_left > 0);
            if (stall_left > 0) stall_left--;
            if (nz && vcyc == 2 && inst == stop_inst) stop = 1;
            if (nz && vcyc == 1 && inst == restart_inst) begin
                start     = 1;
                mode      = 2'd1;
                num_instr = 16'd1;
            end
            if (dv_q.size() > 0) begin
                dif.dir_valid  = 1;
                dif.dir_is_mem = dv_q[0].is_mem;
                dif.dir_code   = dv_q[0].code;
                dif.dir_addr   = dv_q[0].addr;
                dif.dir_last   = dv_q[0].last;
            end else begin
                dif.dir_valid = 0;
            end
            #4;
            if (sw_after > 0 && n_acc >= sw_after && dif.dir_ready) ready_late++;
            if (dif.dir_valid && dif.dir_ready) begin
                void'(dv_q.pop_front());
                n_acc++;
            end
            cyc++;
        end
        dif.dir_valid = 0;
        stall = 0;
        stop  = 0;
        start = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (mem_op !== '0) begin n_fail++; $display("FAIL rst_mem: got %h, required 0", mem_op); end
        n_checks++;
        if (op7_op !== '0) begin n_fail++; $display("FAIL rst_op7: got %h, required 0", op7_op); end
        n_checks++;
        if (dif.dir_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b, required 0", dif.dir_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, required 0", done); end
        n_checks++;
        if (issued_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", issued_count); end
        n_checks++;
        if (base_addr !== 12'o0200) begin n_fail++; $display("FAIL base_addr: got %o, required 0200", base_addr); end
    endtask

    task automatic test_directed();
        push_vec(1, 22'h20, 12'd1, 0);
        push_vec(1, 22'h10, 12'd3, 0);
        push_vec(0, 22'h200000, 12'd0, 0);
        push_exp(1, 22'h20, 12'd1, 2, -1);
        push_exp(1, 22'h10, 12'd3, 2, 2);
        push_exp(0, 22'h200000, 12'd0, 2, 2);
        start_run(2'd0, 16'd3);
        run(200, 0, 0, 0, 0, 0);
        n_checks++;
        if (first_nz !== 1) begin n_fail++; $display("FAIL dir_latency: got %0d, required 1 (2 posedges)", first_nz); end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL dir_done: got %b, required 1", done); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL dir_busy: got %b, required 0", busy); end
        n_checks++;
        if (issued_count !== 16'd3) begin n_fail++; $display("FAIL dir_count: got %0d, required 3", issued_count); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL dir_missing: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        push_vec(1, 22'h04, 12'o0777, 0);
        push_exp(1, 22'h04, 12'o0777, 7, -1);
        start_run(2'd0, 16'd1);
        run(200, 1, 5, 0, 0, 0);
        n_checks++;
        if (issued_count !== 16'd1) begin n_fail++; $display("FAIL stall_count: got %0d, required 1", issued_count); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stall_missing: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_random();
        int worst = 0;
        do_reset();
        push_random(50, -1);
        rec_q.delete();
        rec_en = 1;
        start_run(2'd1, 16'd50);
        run(4000, 0, 0, 0, 0, 0);
        rec_en = 0;
        n_checks++;
        if (issued_count !== 16'd50) begin n_fail++; $display("FAIL rnd_count: got %0d, required 50", issued_count); end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL rnd_done: got %b, required 1", done); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rnd_missing: got %0d pending, required 0", exp_q.size()); end
        for (int i = 1; i < rec_q.size(); i++)
            if (rec_q[i].idle - 2 > worst) worst = rec_q[i].idle - 2;
        n_checks++;
        if (worst > MAXD) begin n_fail++; $display("FAIL rnd_gap: got max delay %0d, required <= %0d", worst, MAXD); end
    endtask

    task automatic test_repro();
        ins_t e;
        do_reset();
        for (int i = 0; i < rec_q.size(); i++) begin
            e = rec_q[i];
            if (i == 0) e.idle = -1;
            exp_q.push_back(e);
            m_lfsr = lfsr_step(m_lfsr);
        end
        start_run(2'd1, 16'd50);
        run(4000, 0, 0, 0, 0, 0);
        n_checks++;
        if (issued_count !== 16'd50) begin n_fail++; $display("FAIL rep_count: got %0d, required 50", issued_count); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rep_missing: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_mode2();
        push_vec(1, 22'h08, 12'o0100, 0);
        push_vec(0, 22'h000400, 12'd0, 1);
        push_vec(1, 22'h01, 12'd7, 0);
        push_exp(1, 22'h08, 12'o0100, 2, -1);
        push_exp(0, 22'h000400, 12'd0, 2, 2);
        push_random(4, 2);
        start_run(2'd2, 16'd6);
        run(1000, 0, 0, 0, 0, 2);
        n_checks++;
        if (issued_count !== 16'd6) begin n_fail++; $display("FAIL m2_count: got %0d, required 6", issued_count); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL m2_missing: got %0d pending, required 0", exp_q.size()); end
        n_checks++;
        if (ready_late !== 0) begin n_fail++; $display("FAIL m2_ready: got %0d ready cycles after switch, required 0", ready_late); end
        n_checks++;
        if (dv_q.size() !== 1) begin n_fail++; $display("FAIL m2_vectors: got %0d left, required 1", dv_q.size()); end
        dv_q.delete();
    endtask

    task automatic test_stop();
        push_vec(1, 22'h02, 12'd10, 0);
        push_vec(0, 22'h000010, 12'd0, 0);
        push_vec(1, 22'h01, 12'd11, 0);
        push_vec(0, 22'h000020, 12'd0, 0);
        push_exp(1, 22'h02, 12'd10, 2, -1);
        push_exp(0, 22'h000010, 12'd0, 2, 2);
        start_run(2'd0, 16'd0);
        run(500, 0, 0, 2, 1, 0);
        n_checks++;
        if (issued_count !== 16'd2) begin n_fail++; $display("FAIL stop_count: got %0d, required 2", issued_count); end
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL stop_done: got %b, required 1", done); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL stop_missing: got %0d pending, required 0", exp_q.size()); end
        n_checks++;
        if (dv_q.size() !== 2) begin n_fail++; $display("FAIL stop_vectors: got %0d left, required 2", dv_q.size()); end
        dv_q.delete();
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        start_run(2'd1, 16'd0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 0;
            if (mem_op != '0 || op7_op != '0) begin
                seen = 1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rmid_issue: got no opcode in 100 cycles, required one"); end
        #2;
        mon_en  = 0;
        reset_n = 0;
        #1;
        n_checks++;
        if (mem_op !== '0) begin n_fail++; $display("FAIL rmid_mem: got %h, required 0", mem_op); end
        n_checks++;
        if (op7_op !== '0) begin n_fail++; $display("FAIL rmid_op7: got %h, required 0", op7_op); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b, required 0", busy); end
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        exp_q.delete();
        m_lfsr = 32'h1;
        mon_en = 1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got done=%b, required 0", done); end
        push_vec(0, 22'h000001, 12'd0, 0);
        push_exp(0, 22'h000001, 12'd0, 2, -1);
        start_run(2'd0, 16'd1);
        run(200, 0, 0, 0, 0, 0);
        n_checks++;
        if (issued_count !== 16'd1) begin n_fail++; $display("FAIL rmid_count: got %0d, required 1", issued_count); end
        n_checks++;
        if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rmid_missing: got %0d pending, required 0", exp_q.size()); end
    endtask

    initial begin
        reset_n  = 0;
        pc_value = 12'd0;
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_repro();
        test_mode2();
        test_stop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
